// File: rtl/uart_rx_cfg_pkg.sv
// Shared definitions for the configurable UART receiver: FSM state encodings,
// parity_mode encodings and a constant-evaluable ceil(log2) helper.
package uart_rx_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic [1:0] PM_NONE     = 2'b00;
    localparam logic [1:0] PM_EVEN     = 2'b01;
    localparam logic [1:0] PM_ODD      = 2'b10;
    localparam logic [1:0] PM_NONE_ALT = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO; head reads as zero while empty so the
// outputs are clean out of reset. Pointers carry one extra wrap bit.
module uart_rx_fifo
    import uart_rx_cfg_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             tick,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             full,
    output logic             valid,
    output logic             pop,
    output logic [WIDTH-1:0] head
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty;
    logic             wr_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign valid = !empty;
    assign pop   = valid && ready;
    // A pop on the same tick frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign head  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge tick) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge tick or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with per-frame parity mode, stop-bit checking,
// break detection and a small FWFT receive FIFO.
module uart_rx_cfg
    import uart_rx_cfg_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 tick,
    input  logic                 reset,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] data,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun,
    output logic                 break_det,
    output logic [2:0]           state
);

    localparam int CW = clog2(OVERSAMPLE);
    localparam int BW = clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

    rx_state_t              state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic [1:0]             mode_reg, mode_next;
    logic                   pbit_reg, pbit_next;
    logic                   ferr_reg, ferr_next;
    logic                   sync1_reg, rxs_reg, rxs_d1_reg, rxs_d2_reg;
    logic                   overrun_reg, break_reg;
    logic                   maj, sample, parity_en, perr, push, brk;
    logic                   fifo_full, fifo_pop;
    logic [DATA_BITS+1:0]   push_word, head_word;

    assign maj       = (rxs_reg & rxs_d1_reg) | (rxs_reg & rxs_d2_reg) | (rxs_d1_reg & rxs_d2_reg);
    assign sample    = (cnt_reg == BIT_LAST);
    assign parity_en = (mode_reg == PM_EVEN) || (mode_reg == PM_ODD);
    assign perr      = parity_en && (((^shift_reg) ^ pbit_reg) != (mode_reg == PM_ODD));
    assign push_word = {perr, ferr_reg | ~maj, shift_reg};

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        mode_next    = mode_reg;
        pbit_next    = pbit_reg;
        ferr_next    = ferr_reg;
        push         = 1'b0;
        brk          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (!rxs_reg) begin
                    state_next   = ST_START;
                    bit_cnt_next = '0;
                    mode_next    = parity_mode;
                    pbit_next    = 1'b0;
                    ferr_next    = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    state_next = rxs_reg ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample) begin
                    cnt_next   = '0;
                    shift_next = {maj, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == BW'(DATA_BITS - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = parity_en ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    cnt_next   = '0;
                    pbit_next  = maj;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    cnt_next = '0;
                    // pbit_reg is cleared per frame, so it reads 0 when no parity bit exists
                    if (bit_cnt_reg == '0 && !maj && shift_reg == '0 && !pbit_reg) begin
                        brk        = 1'b1;
                        state_next = ST_WAIT_IDLE;
                    end else if (bit_cnt_reg == BW'(STOP_BITS - 1)) begin
                        push       = 1'b1;
                        state_next = (ferr_reg || !maj) ? ST_WAIT_IDLE : ST_IDLE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        ferr_next    = ferr_reg | ~maj;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_next = '0;
                if (rxs_reg) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge tick or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            mode_reg    <= PM_NONE;
            pbit_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            sync1_reg   <= 1'b1;
            rxs_reg     <= 1'b1;
            rxs_d1_reg  <= 1'b1;
            rxs_d2_reg  <= 1'b1;
            overrun_reg <= 1'b0;
            break_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            mode_reg    <= mode_next;
            pbit_reg    <= pbit_next;
            ferr_reg    <= ferr_next;
            sync1_reg   <= rx;
            rxs_reg     <= sync1_reg;
            rxs_d1_reg  <= rxs_reg;
            rxs_d2_reg  <= rxs_d1_reg;
            overrun_reg <= push && fifo_full && !fifo_pop;
            break_reg   <= brk;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .tick      (tick),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .ready     (ready),
        .full      (fifo_full),
        .valid     (valid),
        .pop       (fifo_pop),
        .head      (head_word)
    );

    assign data       = head_word[DATA_BITS-1:0];
    assign frame_err  = head_word[DATA_BITS];
    assign parity_err = head_word[DATA_BITS+1];
    assign overrun    = overrun_reg;
    assign break_det  = break_reg;
    assign state      = state_reg;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, tick cycles per bit (even, legal 8..64).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits checked (legal 1 or 2).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of two, >= 2).
REQ-005 SHALL have port tick  in  1  the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx  in  1  asynchronous serial line, idle high.
REQ-008 SHALL have port parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 SHALL have port data  out  DATA_BITS  FIFO head data.
REQ-010 SHALL have port frame_err  out  1  FIFO head stop-bit error flag.
REQ-011 SHALL have port parity_err  out  1  FIFO head parity error flag.
REQ-012 SHALL have port valid  out  1  FIFO non-empty.
REQ-013 SHALL have port ready  in  1  consumer accepts head.
REQ-014 SHALL have port overrun  out  1  one-tick pulse, frame dropped because FIFO full.
REQ-015 SHALL have port break_det  out  1  one-tick pulse, break detected.
REQ-016 SHALL have port state  out  3  current FSM state (debug).

Function
REQ-017 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value rxs.
REQ-018 SHALL implement states IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5.
REQ-019 IDLE: on rxs=0, SHALL go to START, clear bit counter, latch parity_mode for the frame.
REQ-020 START: at tick OVERSAMPLE/2-1 after entry, SHALL return to IDLE if rxs=1 (glitch), else go to DATA.
REQ-021 SHALL sample every later bit exactly OVERSAMPLE ticks after the previous sample, value = majority of rxs on that tick and the two ticks before.
REQ-022 DATA: SHALL shift in DATA_BITS bits LSB-first, then go to PARITY if latched mode is even/odd, else STOP.
REQ-023 PARITY: parity_err SHALL be set when (XOR of data bits XOR parity bit) differs from 0 for even, 1 for odd.
REQ-024 STOP: SHALL sample STOP_BITS stop bits; frame_err set if any sample is 0.
REQ-025 Break: data all zero, parity bit (if present) zero, and first stop sample zero -> pulse break_det, push nothing, go to WAIT_IDLE.
REQ-026 Otherwise SHALL push {parity_err, frame_err, data} on the last stop sample tick and return to IDLE on the next tick; frame_err frames go to WAIT_IDLE instead.
REQ-027 WAIT_IDLE: SHALL go to IDLE after rxs=1 for one tick.
REQ-028 FIFO SHALL be first-word fall-through: valid=!empty; head on data/frame_err/parity_err; pop when valid&&ready.
REQ-029 Push when full and no pop: frame dropped, overrun pulses one tick, contents unchanged.
REQ-030 Simultaneous push and pop SHALL both succeed, including when full or empty (empty: pop ignored since valid=0).
REQ-031 Latency: valid SHALL rise one tick after the push tick when the FIFO was empty.
REQ-032 Pointer arithmetic SHALL use log2(FIFO_DEPTH)+1 bits; wrap-around modulo depth.

Reset
REQ-033 Asserted reset SHALL force: state=IDLE, synchronizer flops=1, counters=0, FIFO empty, valid=0, data=0, frame_err=0, parity_err=0, overrun=0, break_det=0.
REQ-034 Reset mid-frame SHALL discard the partial frame; no push after release.
REQ-035 After reset release, a frame SHALL be accepted only from a fresh falling edge.

Structure
REQ-036 Shared package SHALL hold state encodings, parity_mode encodings and a clog2 function.
REQ-037 FIFO SHALL be a sub-module uart_rx_fifo (parameters WIDTH, DEPTH).

Verification (OVERSAMPLE=16, DATA_BITS=8, FIFO_DEPTH=4)
REQ-038 rx 8N1 0xAA, ready=1 -> valid pulse with data=0xAA, frame_err=0, parity_err=0.
REQ-039 rx low for 4 ticks then high -> state returns to IDLE, valid stays 0.
REQ-040 parity_mode=01, 0x55 with parity bit 1 -> data=0x55, parity_err=1.
REQ-041 0x3C with stop bit 0 -> data=0x3C, frame_err=1, state=WAIT_IDLE until rx high.
REQ-042 ready=0, five frames 0x01..0x05 -> overrun pulses once; pops yield 0x01..0x04.
REQ-043 reset asserted during bit 3 of 0x0F -> no valid; next frame 0x81 received correctly; line held low 12 bit-times -> one break_det pulse, no push.
